// File: rtl/seq_divider_if.sv
// Start/result handshake bundle for seq_divider.
// SEQ_DIVIDER_SIGNED_EN adds the signed_op request bit.
interface seq_divider_if #(
  parameter int WORD_LENGTH = 32
);
  logic                   start;
  logic [WORD_LENGTH-1:0] A0;
  logic [WORD_LENGTH-1:0] A1;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic                   signed_op;
`endif
  logic                   ready;
  logic                   done;
  logic [WORD_LENGTH-1:0] quotient;
  logic [WORD_LENGTH-1:0] remainder;
  logic                   div_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
  modport master (
    output start, A0, A1, signed_op,
    input  ready, done, quotient, remainder, div_zero
  );
  modport slave (
    input  start, A0, A1, signed_op,
    output ready, done, quotient, remainder, div_zero
  );
`else
  modport master (
    output start, A0, A1,
    input  ready, done, quotient, remainder, div_zero
  );
  modport slave (
    input  start, A0, A1,
    output ready, done, quotient, remainder, div_zero
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// Restoring radix-2 divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for the two's-complement signed_op path.
module seq_divider #(
  parameter int WORD_LENGTH = 32
) (
  input logic         clk,
  input logic         reset,
  seq_divider_if.slave bus
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd;
  logic [W-1:0]  dvs;
  logic [W-1:0]  rem;
  logic          neg_q;
  logic          neg_r;

  logic [W-1:0]  quo_r;
  logic [W-1:0]  rem_r;
  logic          dz_r;

  logic [W:0]    shf;
  logic [W:0]    trial;
  logic          q_bit;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  quo_nx;
  logic [W-1:0]  q_fix;
  logic [W-1:0]  r_fix;

  logic [W-1:0]  a0_in;
  logic [W-1:0]  a1_in;
  logic          nq_in;
  logic          nr_in;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic s0;
  logic s1;

  always_comb begin
    s0    = bus.signed_op & bus.A0[W-1];
    s1    = bus.signed_op & bus.A1[W-1];
    a0_in = s0 ? -bus.A0 : bus.A0;
    a1_in = s1 ? -bus.A1 : bus.A1;
    nq_in = s0 ^ s1;
    nr_in = s0;
  end
`else
  always_comb begin
    a0_in = bus.A0;
    a1_in = bus.A1;
    nq_in = 1'b0;
    nr_in = 1'b0;
  end
`endif

  // Shifted remainder keeps its top bit so divisors above 2^(W-1) work.
  always_comb begin
    shf    = {rem, dvd[W-1]};
    trial  = shf - {1'b0, dvs};
    q_bit  = ~trial[W];
    rem_nx = q_bit ? trial[W-1:0] : shf[W-1:0];
    quo_nx = {dvd[W-2:0], q_bit};
    q_fix  = (neg_q && (dvs != '0)) ? -quo_nx : quo_nx;
    r_fix  = neg_r ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quo_r <= '0;
      rem_r <= '0;
      dz_r  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            dvd   <= a0_in;
            dvs   <= a1_in;
            rem   <= '0;
            neg_q <= nq_in;
            neg_r <= nr_in;
            cnt   <= CW'(W);
            state <= CALC;
          end
        end
        (state == CALC): begin
          dvd <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quo_r <= q_fix;
            rem_r <= r_fix;
            dz_r  <= (dvs == '0);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = dz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, scoreboard
// queue, held-start throughput, mid-operation reset, signed cases.
module tb_seq_divider;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  seq_divider_if #(.WORD_LENGTH(W)) bus ();

  seq_divider #(.WORD_LENGTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done = -1;
  bit   chk_gap = 1'b0;
  exp_t sb[$];
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sgn_op = 1'b0;
`endif

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (chk_gap && last_done >= 0)
        check("done_gap", W'(cyc - last_done), W'(W + 2));
      last_done = cyc;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no pulse at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_zero", W'(bus.div_zero), W'(e.dz));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e);
    int n;
    bit rdy_ok;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_wait: got ready=%b want 1", bus.ready);
      return;
    end
    bus.A0    = a;
    bus.A1    = b;
    bus.start = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
    bus.signed_op = sgn_op;
`endif
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A0    = ~a;
    bus.A1    = a ^ b ^ 32'h5a5a_1234;
    n = 0;
    rdy_ok = 1'b1;
    while (bus.done !== 1'b1 && n < W + 8) begin
      if (bus.ready !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", W'(n), W'(W));
    check("ready_low", W'(rdy_ok), W'(1));
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.q  = v.q;
    e.r  = v.r;
    e.dz = v.dz;
    run_op(v.a0, v.a1, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[9];
    int   n;
    int   np;
    int   d0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    tv[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    tv[1] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
    tv[2] = '{32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
    tv[3] = '{32'd1234,      32'd0,         32'hFFFF_FFFF, 32'd1234,      1'b1};
    tv[4] = '{32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF,         1'b0};
    tv[5] = '{32'h8000_0000, 32'h8000_0001, 32'd0,         32'h8000_0000, 1'b0};
    tv[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    tv[7] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'd1,         32'h7FFF_FFFE, 1'b0};
    tv[8] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};

    bus.start = 1'b0;
    bus.A0    = '0;
    bus.A1    = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", W'(bus.ready), W'(1));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_quotient", bus.quotient, '0);
    check("rst_remainder", bus.remainder, '0);
    check("rst_div_zero", W'(bus.div_zero), W'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(tv[i]);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i < 2) ? W'($urandom_range(1, 65535)) : W'($urandom);
      run_op(ra, rb, model(ra, rb));
    end

    // start held high; operands churn while busy
    chk_gap   = 1'b1;
    last_done = -1;
    d0        = done_cnt;
    np        = 0;
    bus.A0    = 32'd1000;
    bus.A1    = 32'd7;
    bus.start = 1'b1;
    for (int c = 0; c < 3 * (W + 2); c++) begin
      if (bus.ready === 1'b1) begin
        sb.push_back(model(bus.A0, bus.A1));
        np++;
      end else begin
        bus.A0 = $urandom;
        bus.A1 = W'($urandom_range(1, 5000));
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk_gap = 1'b0;
    check("held_starts", W'(np), W'(3));
    check("held_results", W'(done_cnt - d0), W'(3));
    check("held_drain", W'(sb.size()), W'(0));
    sb.delete();
    @(negedge clk);

    // reset pulsed during iteration 10
    bus.A0    = 32'd1000;
    bus.A1    = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_ready", W'(bus.ready), W'(1));
    check("abort_done", W'(bus.done), W'(0));
    check("abort_quotient", bus.quotient, '0);
    check("abort_remainder", bus.remainder, '0);
    check("abort_div_zero", W'(bus.div_zero), W'(0));
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (W + 5) @(negedge clk);
    check("abort_no_done", W'(done_cnt - d0), W'(0));
    run_vec('{32'd50, 32'd5, 32'd10, 32'd0, 1'b0});

`ifdef SEQ_DIVIDER_SIGNED_EN
    sgn_op = 1'b1;
    run_vec('{32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    run_vec('{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0});
    run_vec('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0});
    run_vec('{32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
    sgn_op = 1'b0;
    run_vec('{32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         1'b0});
`endif

    repeat (3) @(negedge clk);
    check("final_queue", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
